updown_counter_param: RTL and testbench

Parametrised up/down counter, the successor to the fixed 8-bit up-counter. It adds the following over that design:
- configurable width and modulus
- direction control, count enable and synchronous load
- wrap or saturate mode and an enable prescaler
- terminal-count, sticky-overflow and compare-match outputs

It is the general counting primitive for timers, address generators and event counters in the design.

---
 rtl/updown_counter_param.sv | 95 +++++++++
 tb/tb_updown_counter_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate boundaries, enable prescaler,
// synchronous clamped load, one-cycle terminal-count pulse, sticky overflow and compare match.
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Qout,
  output logic             tc,
  output logic             ovf,
  output logic             match
);

  // A single-step prescaler still gets one register bit; it simply never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;

  always_comb begin
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    step     = 1'b0;
    at_bound = 1'b0;

    if (load) begin
      cnt_d = (load_val > MAX_Q) ? MAX_Q : load_val;
      ps_d  = '0;
    end else if (en) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        step = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end

    if (step) begin
      if (up_dn) begin
        if (cnt_q == MAX_Q) begin
          at_bound = 1'b1;
          cnt_d    = (SATURATE != 0) ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          at_bound = 1'b1;
          cnt_d    = (SATURATE != 0) ? cnt_q : MAX_Q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    // A boundary event in the same cycle as clr_ovf keeps the flag set.
    tc_d  = at_bound;
    ovf_d = at_bound | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ps_q  <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Qout  = cnt_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign match = (cnt_q == cmp_val);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations (wrap, saturate, prescale-3) share one
// stimulus stream and are checked every cycle against an arithmetic model plus literal pins.
module tb_updown_counter_param;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0, up_dn = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [W-1:0] load_val = '0, cmp_val = '0;

  logic [W-1:0] q0, q1, q2;
  logic         tc0, tc1, tc2, ovf0, ovf1, ovf2, m0, m1, m2;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  run = 0;

  // model state per instance: 0 = wrap, 1 = saturate, 2 = wrap with prescale 3
  int  m_q[3], m_ps[3];
  bit  m_tc[3], m_ovf[3];
  int  sat_cfg[3] = '{0, 1, 0};
  int  pre_cfg[3] = '{1, 1, 3};

  updown_counter_param #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cmp_val(cmp_val), .clr_ovf(clr_ovf), .Qout(q0), .tc(tc0), .ovf(ovf0), .match(m0));
  updown_counter_param #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cmp_val(cmp_val), .clr_ovf(clr_ovf), .Qout(q1), .tc(tc1), .ovf(ovf1), .match(m1));
  updown_counter_param #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cmp_val(cmp_val), .clr_ovf(clr_ovf), .Qout(q2), .tc(tc2), .ovf(ovf2), .match(m2));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_ps[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit bnd;
    bit stp;
    bnd = 0;
    stp = 0;
    if (load) begin
      m_q[k]  = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_ps[k] = 0;
    end else if (en) begin
      m_ps[k] = (m_ps[k] + 1) % pre_cfg[k];
      stp = (m_ps[k] == 0);
    end
    if (stp) begin
      if (up_dn) begin
        bnd = (m_q[k] == MAXV);
        if (sat_cfg[k] != 0) m_q[k] = (m_q[k] + 1 > MAXV) ? MAXV : m_q[k] + 1;
        else                 m_q[k] = (m_q[k] + 1) % (MAXV + 1);
      end else begin
        bnd = (m_q[k] == 0);
        if (sat_cfg[k] != 0) m_q[k] = (m_q[k] - 1 < 0) ? 0 : m_q[k] - 1;
        else                 m_q[k] = (m_q[k] + MAXV) % (MAXV + 1);
      end
    end
    m_tc[k]  = bnd;
    m_ovf[k] = bnd || (m_ovf[k] && !clr_ovf);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic cmp_inst(input int k, input logic [W-1:0] q, input logic t, input logic o,
                          input logic m);
    chk($sformatf("q%0d", k),     q, m_q[k]);
    chk($sformatf("tc%0d", k),    t, m_tc[k]);
    chk($sformatf("ovf%0d", k),   o, m_ovf[k]);
    chk($sformatf("match%0d", k), m, (m_q[k] == int'(cmp_val)));
  endtask

  // per-cycle compare, 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (run) begin
      cmp_inst(0, q0, tc0, ovf0, m0);
      cmp_inst(1, q1, tc1, ovf1, m1);
      cmp_inst(2, q2, tc2, ovf2, m2);
    end
  end

  // driver: inputs change 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int v);
    load_val = W'(v);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    run = 1;
    reset = 1'b1;
    chk("reset_q", q0, 0);
    chk("reset_tc", tc0, 0);
    chk("reset_ovf", ovf0, 0);
    chk("reset_match", m0, 1);

    // wrap up 0..9..0, prescaled copy steps every third edge
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("wrap_up_q", q0, i % 10);
      chk("wrap_up_tc", tc0, (i == 10));
      chk("pre_q", q2, i / 3);
    end
    chk("wrap_up_ovf", ovf0, 1);
    chk("sat_hold_first", q1, 9);

    // wrap down then direction change
    en = 1'b0;
    do_load(2);
    chk("load2_q", q0, 2);
    en = 1'b1; up_dn = 1'b0;
    tick(); chk("down_1", q0, 1); chk("down_1_tc", tc0, 0);
    tick(); chk("down_0", q0, 0);
    tick(); chk("down_9", q0, 9); chk("down_9_tc", tc0, 1);
    up_dn = 1'b1;
    tick(); chk("flip_0", q0, 0);
    tick(); chk("flip_1", q0, 1);

    // saturate at top
    en = 1'b0;
    do_load(9);
    chk("sat_load", q1, 9);
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_q", q1, 9);
      chk("sat_tc", tc1, 1);
      chk("sat_ovf", ovf1, 1);
    end
    clr_ovf = 1'b1;
    tick(); chk("sat_clr_with_step", ovf1, 1);
    en = 1'b0;
    tick(); chk("sat_clr_alone", ovf1, 0);
    clr_ovf = 1'b0;

    // load priority and clamp, then match
    en = 1'b1;
    do_load(12);
    chk("clamp_q", q0, 9);
    chk("clamp_tc", tc0, 0);
    cmp_val = 4'd5;
    do_load(5);
    en = 1'b0;
    chk("match_after_load", m0, 1);

    // prescaler pauses while en is low
    do_load(0);
    en = 1'b1;
    tick(); tick();
    chk("pre_two_edges", q2, 0);
    en = 1'b0;
    repeat (4) tick();
    chk("pre_paused", q2, 0);
    en = 1'b1;
    tick();
    chk("pre_resume_step", q2, 1);

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 2) != 0);
      load     = ($urandom_range(0, 15) == 0);
      clr_ovf  = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 15));
      cmp_val  = W'($urandom_range(0, 9));
      tick();
    end
    load = 1'b0; clr_ovf = 1'b0;

    // async reset mid-count
    en = 1'b1; up_dn = 1'b1;
    do_load(9);
    tick();
    chk("pre_rst_wrap_ovf", ovf0, 1);
    do_load(6);
    tick();
    chk("pre_rst_q", q0, 7);
    chk("pre_rst_ovf", ovf0, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_q", q0, 0);
    chk("async_tc", tc0, 0);
    chk("async_ovf", ovf0, 0);
    tick();
    reset = 1'b1;
    tick(); chk("resume_1", q0, 1);
    tick(); chk("resume_2", q0, 2);

    en = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
